// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game constants, FSM state type and random-draw helpers
package tetris_pkg;

    localparam int NUM_BLOCKS = 7;

    // Playfield size shared with the field block
    localparam int FIELD_W = 10;
    localparam int FIELD_H = 20;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_PLAY,
        ST_OVER
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    // Three random bits give 0..7; 7 is not a piece, so step on from the previous one
    function automatic logic [2:0] draw_piece(input logic [2:0] p, input logic [2:0] prev);
        if (p != 3'd7)
            return p;
        if (prev == 3'(NUM_BLOCKS - 1))
            return 3'd0;
        return prev + 3'd1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop button synchronizer with one-pulse-per-press edge detect
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    // Synchronize the raw button, then keep a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s2_d;

endmodule

// File: rtl/block_dispatch.sv
// rtl/block_dispatch.sv - game-flow controller: piece draw, move pulses, gravity, score and level
module block_dispatch
    import tetris_pkg::*;
#(
    parameter int TICK_BASE = 25_000_000,
    parameter int TICK_STEP = 1_000_000,
    parameter int TICK_MIN  = 2_000_000,
    parameter int LEVEL_PTS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_down,
    input  logic        btn_rot,
    input  logic        next_block,
    input  logic [9:0]  score_plus,
    input  logic        gameover,
    output logic [9:0]  block_num,
    output logic        left,
    output logic        right,
    output logic        down,
    output logic [9:0]  ro,
    output logic [15:0] score,
    output logic [3:0]  level,
    output logic        playing
);

    localparam logic [15:0] LVL_PTS16  = 16'(LEVEL_PTS);
    localparam logic [31:0] TICK_MIN32 = 32'(TICK_MIN);
    localparam logic [31:0] TICK_BASE32 = 32'(TICK_BASE);

    logic w_start;
    logic w_left;
    logic w_right;
    logic w_down;
    logic w_rot;

    btn_sync_edge u_start (.clk(clk), .rst_n(rst_n), .i_btn(btn_start), .o_pulse(w_start));
    btn_sync_edge u_left  (.clk(clk), .rst_n(rst_n), .i_btn(btn_left),  .o_pulse(w_left));
    btn_sync_edge u_right (.clk(clk), .rst_n(rst_n), .i_btn(btn_right), .o_pulse(w_right));
    btn_sync_edge u_down  (.clk(clk), .rst_n(rst_n), .i_btn(btn_down),  .o_pulse(w_down));
    btn_sync_edge u_rot   (.clk(clk), .rst_n(rst_n), .i_btn(btn_rot),   .o_pulse(w_rot));

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic        r_nb_q;
    logic [31:0] r_cnt;
    logic [31:0] r_period;
    logic [31:0] r_period_cur;
    logic [15:0] r_pts_acc;
    logic [15:0] r_score;
    logic [3:0]  r_level;
    logic [2:0]  r_block;
    logic        r_left;
    logic        r_right;
    logic        r_down;
    logic        r_ro0;
    logic        r_playing;

    logic signed [31:0] w_period_raw;
    logic [31:0]        w_period_next;
    logic               w_nb_edge;
    logic               w_tick;
    logic               w_add;
    logic               w_lvl_up;
    logic [16:0]        w_score_sum;
    logic [15:0]        w_score_next;
    logic [15:0]        w_pts_base;
    logic [16:0]        w_pts_sum;
    logic [15:0]        w_pts_next;

    assign w_period_raw  = TICK_BASE - TICK_STEP * $signed({28'd0, r_level});
    assign w_period_next = (w_period_raw < $signed(TICK_MIN)) ? TICK_MIN32 : w_period_raw;

    assign w_nb_edge = next_block & ~r_nb_q;
    assign w_tick    = (r_cnt == r_period_cur - 32'd1);
    assign w_add     = (r_state == ST_PLAY) && w_nb_edge;
    assign w_lvl_up  = (r_pts_acc >= LVL_PTS16);

    assign w_score_sum  = {1'b0, r_score} + {7'd0, score_plus};
    assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    // Level-up drains one LEVEL_PTS per cycle; leftover points carry to later cycles
    assign w_pts_base = r_pts_acc - (w_lvl_up ? LVL_PTS16 : 16'd0);
    assign w_pts_sum  = {1'b0, w_pts_base} + {7'd0, (w_add ? score_plus : 10'd0)};
    assign w_pts_next = w_pts_sum[16] ? 16'hFFFF : w_pts_sum[15:0];

    // Free-running random source and next_block edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_nb_q <= 1'b0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            r_nb_q <= next_block;
        end
    end

    // Gravity period follows the level one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_period <= TICK_BASE32;
        else
            r_period <= w_period_next;
    end

    // Game FSM with registered pulse outputs, gravity counter and score/level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 32'd0;
            r_period_cur <= TICK_BASE32;
            r_pts_acc    <= 16'd0;
            r_score      <= 16'd0;
            r_level      <= 4'd0;
            r_block      <= 3'd0;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_down       <= 1'b0;
            r_ro0        <= 1'b0;
            r_playing    <= 1'b0;
        end else begin
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_down    <= 1'b0;
            r_ro0     <= 1'b0;
            r_pts_acc <= w_pts_next;
            if (w_lvl_up && r_level != 4'd15)
                r_level <= r_level + 4'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_SPAWN;
                        r_playing <= 1'b1;
                    end
                end
                ST_SPAWN: begin
                    r_block      <= draw_piece(r_lfsr[2:0], r_block);
                    r_cnt        <= 32'd0;
                    // Level may have just been cleared, so take the live period here
                    r_period_cur <= w_period_next;
                    r_state      <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_tick) begin
                        r_cnt        <= 32'd0;
                        r_period_cur <= r_period;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                    if (w_nb_edge)
                        r_score <= w_score_next;
                    // Outputs stay quiet on the leaving cycle so none show in SPAWN/OVER
                    if (gameover) begin
                        r_state   <= ST_OVER;
                        r_playing <= 1'b0;
                    end else if (w_nb_edge) begin
                        r_state <= ST_SPAWN;
                    end else begin
                        r_left  <= w_left & ~w_right;
                        r_right <= w_right & ~w_left;
                        r_down  <= w_tick | w_down;
                        r_ro0   <= w_rot;
                    end
                end
                ST_OVER: begin
                    if (w_start) begin
                        r_score   <= 16'd0;
                        r_level   <= 4'd0;
                        r_pts_acc <= 16'd0;
                        r_state   <= ST_SPAWN;
                        r_playing <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign block_num = {7'd0, r_block};
    assign left      = r_left;
    assign right     = r_right;
    assign down      = r_down;
    assign ro        = {9'd0, r_ro0};
    assign score     = r_score;
    assign level     = r_level;
    assign playing   = r_playing;

endmodule

// File: tb/tb_block_dispatch.sv
// tb/tb_block_dispatch.sv - scoreboard testbench for block_dispatch
module tb_block_dispatch;

    localparam int P_BASE = 20;
    localparam int P_STEP = 5;
    localparam int P_MIN  = 8;
    localparam int P_LVL  = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_rot = 1'b0;
    logic        next_block = 1'b0;
    logic [9:0]  score_plus = 10'd0;
    logic        gameover = 1'b0;
    logic [9:0]  block_num;
    logic        left;
    logic        right;
    logic        down;
    logic [9:0]  ro;
    logic [15:0] score;
    logic [3:0]  level;
    logic        playing;

    int n_checks = 0;
    int n_errors = 0;

    int cyc_n = 0;
    int dcnt = 0;
    int lcnt = 0;
    int rcnt = 0;
    int rocnt = 0;
    int ro1cnt = 0;
    int last_down = 0;
    int prev_down = 0;

    logic [15:0] m_lfsr;
    logic [15:0] exp_q[$];
    logic [2:0]  exp_blk = 3'd0;
    int          exp_score = 0;

    block_dispatch #(
        .TICK_BASE(P_BASE),
        .TICK_STEP(P_STEP),
        .TICK_MIN (P_MIN),
        .LEVEL_PTS(P_LVL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .btn_rot   (btn_rot),
        .next_block(next_block),
        .score_plus(score_plus),
        .gameover  (gameover),
        .block_num (block_num),
        .left      (left),
        .right     (right),
        .down      (down),
        .ro        (ro),
        .score     (score),
        .level     (level),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

    // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (down) begin
            dcnt      = dcnt + 1;
            prev_down = last_down;
            last_down = cyc_n;
        end
        if (left)
            lcnt = lcnt + 1;
        if (right)
            rcnt = rcnt + 1;
        if (ro != 10'd0)
            rocnt = rocnt + 1;
        if (ro == 10'd1)
            ro1cnt = ro1cnt + 1;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_piece(input logic [15:0] l, input logic [2:0] prev);
        logic [2:0] p;
        p = l[2:0];
        if (p == 3'd7)
            p = (prev == 3'd6) ? 3'd0 : prev + 3'd1;
        return p;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_block_num"}, block_num, 0);
        check_eq({tag, "_moves"}, {left, right, down}, 0);
        check_eq({tag, "_ro"}, ro, 0);
        check_eq({tag, "_score"}, score, 0);
        check_eq({tag, "_level"}, level, 0);
        check_eq({tag, "_playing"}, playing, 0);
    endtask

    task automatic wait_down(input string tag);
        int s;
        int k;
        s = dcnt;
        k = 0;
        while (dcnt == s && k < 200) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_down_seen"}, (dcnt != s), 1);
    endtask

    task automatic start_game(input string tag);
        int k;
        logic [15:0] e;
        k = 0;
        btn_start = 1'b1;
        while (!playing && k < 10) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_latency_ok"}, (k == 3 || k == 4), 1);
        exp_blk = exp_piece(m_lfsr, exp_blk);
        exp_q.push_back({13'd0, exp_blk});
        tick(1);
        btn_start = 1'b0;
        e = exp_q.pop_front();
        check_eq({tag, "_block"}, block_num, e);
    endtask

    task automatic do_request(input int sp, input string tag);
        logic [15:0] e;
        score_plus = sp[9:0];
        next_block = 1'b1;
        exp_score  = (exp_score + sp > 65535) ? 65535 : exp_score + sp;
        exp_q.push_back(16'(exp_score));
        tick(1);
        e = exp_q.pop_front();
        check_eq({tag, "_score"}, score, e);
        check_eq({tag, "_quiet_spawn"}, {down, left, right, |ro}, 0);
        exp_blk = exp_piece(m_lfsr, exp_blk);
        exp_q.push_back({13'd0, exp_blk});
        tick(1);
        e = exp_q.pop_front();
        check_eq({tag, "_block"}, block_num, e);
        check_eq({tag, "_playing"}, playing, 1);
    endtask

    initial begin
        int s_l;
        int s_r;
        int s_d;
        int s_ro;
        int s_ro1;

        tick(3);
        check_reset("reset");
        rst_n = 1'b1;
        tick(5);
        check_eq("idle_playing", playing, 0);

        // Start and gravity at level 0
        start_game("start");
        check_eq("start_level", level, 0);
        wait_down("grav0");
        wait_down("grav1");
        check_eq("grav_period_20a", last_down - prev_down, 20);
        wait_down("grav2");
        check_eq("grav_period_20b", last_down - prev_down, 20);

        // Start during play is ignored
        btn_start = 1'b1;
        tick(6);
        btn_start = 1'b0;
        tick(3);
        check_eq("start_in_play_block", block_num, exp_blk);
        check_eq("start_in_play_playing", playing, 1);

        // Single left press, left+right together, rotate
        s_l = lcnt; s_r = rcnt;
        btn_left = 1'b1; tick(6); btn_left = 1'b0; tick(3);
        check_eq("left_once", lcnt - s_l, 1);
        check_eq("left_no_right", rcnt - s_r, 0);
        s_l = lcnt; s_r = rcnt;
        btn_left = 1'b1; btn_right = 1'b1; tick(6);
        btn_left = 1'b0; btn_right = 1'b0; tick(3);
        check_eq("lr_conflict_left", lcnt - s_l, 0);
        check_eq("lr_conflict_right", rcnt - s_r, 0);
        s_ro = rocnt; s_ro1 = ro1cnt;
        btn_rot = 1'b1; tick(6); btn_rot = 1'b0; tick(3);
        check_eq("rot_pulse", rocnt - s_ro, 1);
        check_eq("rot_bit0_only", ro1cnt - s_ro1, 1);

        // Down button lined up with a gravity tick: one pulse
        wait_down("align");
        tick(16);
        s_d = dcnt;
        btn_down = 1'b1; tick(5); btn_down = 1'b0; tick(2);
        check_eq("down_coincident", dcnt - s_d, 1);
        s_d = dcnt;
        btn_down = 1'b1; tick(5); btn_down = 1'b0; tick(1);
        check_eq("down_button", dcnt - s_d, 1);

        // Piece request, then held next_block
        do_request(30, "req1");
        tick(30);
        check_eq("hold_block", block_num, exp_blk);
        check_eq("hold_score", score, exp_score);
        next_block = 1'b0;
        tick(3);

        // Level-up to 1: period 15
        do_request(30, "req2");
        next_block = 1'b0;
        tick(3);
        check_eq("level_1", level, 1);
        wait_down("lv1a");
        wait_down("lv1b");
        check_eq("period_15", last_down - prev_down, 15);

        // Large award: carries over two level-ups, period clamps at 8
        do_request(100, "req3");
        next_block = 1'b0;
        tick(5);
        check_eq("level_3", level, 3);
        check_eq("score_160", score, 160);
        wait_down("lv3a");
        wait_down("lv3b");
        check_eq("period_clamp_8", last_down - prev_down, 8);

        // Game over: no pulses, state holds
        gameover = 1'b1;
        tick(1);
        check_eq("over_playing", playing, 0);
        s_l = lcnt; s_r = rcnt; s_d = dcnt; s_ro = rocnt;
        btn_left = 1'b1; btn_down = 1'b1; btn_rot = 1'b1;
        tick(100);
        btn_left = 1'b0; btn_down = 1'b0; btn_rot = 1'b0;
        tick(3);
        check_eq("over_no_pulses", (lcnt - s_l) + (rcnt - s_r) + (dcnt - s_d) + (rocnt - s_ro), 0);
        check_eq("over_score_hold", score, 160);
        check_eq("over_level_hold", level, 3);
        check_eq("over_block_hold", block_num, exp_blk);
        gameover = 1'b0;
        tick(2);

        start_game("restart");
        exp_score = 0;
        check_eq("restart_score", score, exp_score);
        check_eq("restart_level", level, 0);

        // Gameover wins over a simultaneous request, score still added
        tick(5);
        score_plus = 10'd20;
        next_block = 1'b1;
        gameover   = 1'b1;
        exp_score  = 20;
        tick(1);
        check_eq("prio_playing", playing, 0);
        check_eq("prio_score", score, exp_score);
        tick(3);
        check_eq("prio_no_spawn", block_num, exp_blk);
        next_block = 1'b0;
        gameover   = 1'b0;
        tick(2);

        start_game("restart2");
        exp_score = 0;
        check_eq("restart2_score", score, exp_score);
        do_request(40, "req4");
        next_block = 1'b0;
        tick(5);

        // Asynchronous reset mid-game
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        exp_blk   = 3'd0;
        exp_score = 0;
        tick(2);
        rst_n = 1'b1;
        s_d = dcnt;
        tick(30);
        check_eq("post_reset_playing", playing, 0);
        check_eq("post_reset_no_down", dcnt - s_d, 0);
        check_eq("post_reset_block", block_num, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/block_dispatch.md
# block_dispatch

Game-flow controller that drives the control side of the `field` block and answers its piece requests. It supplies the current piece number, issues gravity and debounced player move/rotate pulses, and turns each `next_block` request into a freshly drawn random piece. It also accumulates the `score_plus` reported by the field and raises the difficulty level as score grows. It sits between the board's buttons and `field`.

## Interface
- `TICK_BASE`, default 25_000_000: gravity period in cycles at level 0.
- `TICK_STEP`, default 1_000_000: period reduction per level.
- `TICK_MIN`, default 2_000_000: floor on the gravity period.
- `LEVEL_PTS`, default 100: points per level-up.
- `clk`  in  1: system clock; one clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `btn_start`, `btn_left`, `btn_right`, `btn_down`, `btn_rot`  in  1 each: raw asynchronous push-buttons.
- `next_block`  in  1: level from `field`; high means the piece has landed and a new one is requested.
- `score_plus`  in  10: points from `field`, valid when a `next_block` rising edge is detected.
- `gameover`  in  1: level from the field overlap check.
- `block_num`  out  10: current piece, 0..6 in bits [2:0], upper bits 0.
- `left`, `right`, `down`  out  1 each: one-cycle move pulses to `field`.
- `ro`  out  10: rotate request; bit0 is a one-cycle pulse, bits [9:1] are 0.
- `score`  out  16: accumulated score, saturating at 16'hFFFF.
- `level`  out  4: 0..15, saturating.
- `playing`  out  1: high in SPAWN and PLAY.

## Operation
- **Button path.** Each button goes through a 2-FF synchronizer, then a registered rising-edge detect, giving one pulse per press. No repeat while held.
- **Random source.** 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset. It steps every cycle in every state.
  - Piece draw: p = lfsr[2:0].
  - If p==7, use (previous block_num + 1) mod 7 instead.
- **FSM states:** IDLE, SPAWN, PLAY, OVER.
- **IDLE.** Reset state; all pulse outputs are 0.
  - Start pulse → SPAWN.
- **SPAWN.** Lasts exactly one cycle.
  - Registers the new `block_num`.
  - Clears the gravity counter.
  - Suppresses `left`, `right`, `down` and `ro`.
  - Always goes → PLAY.
- **PLAY.** Forwards button pulses and gravity.
  - `down` = gravity tick OR down-button pulse. Coincident events give one single pulse.
  - `left` and `right` pulsing in the same cycle → neither is emitted.
  - `ro[0]` = rotate pulse.
  - `next_block` rising edge (registered `nb_q`) → SPAWN. In that same edge cycle, `score_plus` is added to the score.
  - `gameover` high → OVER. Gameover takes priority over a simultaneous `next_block` edge, but the score is still added.
- **OVER.** All pulses are 0; `block_num`, `score` and `level` hold.
  - Start pulse → clears score, level and the level accumulator, then → SPAWN.
- **Level logic.** `pts_acc` (16 bit) accumulates `score_plus` alongside the score.
  - When `pts_acc` ≥ `LEVEL_PTS`: subtract `LEVEL_PTS` and increment `level` (saturating at 15).
  - At most one level-up per cycle. Any excess carries over and is resolved on subsequent cycles.
- **Gravity period.** Registered: period = max(TICK_BASE − level·TICK_STEP, TICK_MIN). It is recomputed one cycle after `level` changes.
  - In PLAY the counter counts 0..period−1. `down` pulses in the cycle the counter wraps.
  - A period change takes effect at the next wrap.
- **Reset values.** `block_num`=0, `left`/`right`/`down`=0, `ro`=0, `score`=0, `level`=0, `playing`=0, state=IDLE, LFSR=16'hACE1. Synchronizers and `nb_q` are cleared.
- **Reset mid-game.** Async assert clears everything immediately. Outputs stay at reset values until a start press.

## Timing
- Button edge to output pulse: 3 cycles (2 sync stages + edge register). All outputs are registered.
- `next_block` rises in cycle N:
  - `score` updates at N+1 edge; state = SPAWN during N+1.
  - New `block_num` is valid from N+2; PLAY resumes at N+2.
- First gravity pulse comes `period` cycles after SPAWN.
- A `next_block` held high across SPAWN causes no second request; only rising edges count.
- Start pressed while in PLAY or SPAWN is ignored.

## Structure
- Shared package `tetris_pkg` holds:
  - `NUM_BLOCKS`=7;
  - the state enum (IDLE/SPAWN/PLAY/OVER);
  - the LFSR seed and taps;
  - the field dimensions shared with `field`.
- One sub-module, `btn_sync_edge` (2-FF sync + rising-edge pulse, async active-low reset), instantiated five times.
- FSM, LFSR, gravity counter and score/level logic live in `block_dispatch`.

## Test plan
- **Reset.** Drive `rst_n`=0 mid-PLAY → all outputs return to the reset values listed above within the same cycle; state=IDLE.
- **Start and gravity.** Use TICK_BASE=20. Press start → `playing`=1 after 4 cycles; `block_num` in 0..6; `down` pulses every 20 cycles.
- **Piece request.** `next_block` rises with `score_plus`=30 → `score`=30 at N+1; new `block_num` valid at N+2; no `down` in the SPAWN cycle; holding `next_block` high causes no second spawn.
- **Level-up.** Use LEVEL_PTS=50, TICK_BASE=20, TICK_STEP=5, TICK_MIN=8.
  - Two requests with `score_plus`=30 → `level`=1, period 15.
  - Further requests → period clamps at 8.
- **Button conflicts.** `btn_left`+`btn_right` pressed together → no pulse on either. `btn_down` coincident with a gravity tick → exactly one `down` pulse.
- **Game over.** `gameover`=1 → OVER; no pulses for 100 cycles; `score` holds. Start → `score`=0, `level`=0, SPAWN.
